mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the execute stage's register-writeback bundle and memory request bundle.
- Performs loads and stores over a ready-handshaked data-memory port, aligning and extending load data.
- Presents a registered writeback bundle to WB, stalls upstream while a memory access is outstanding, and flags misaligned or timed-out accesses.

Parameters:
- ADDR_W, 32, data-memory address width.
- TIMEOUT, 255, maximum cycles to wait for dmem_ready before aborting an access (8-bit counter).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- regcData_i  input  32  execute-stage result (ALU or HI/LO move).
- regcAddr_i  input  5  destination register.
- regcWr_i  input  1  register write enable.
- memAddr_i  input  32  effective address.
- memData_i  input  32  store data, right-justified.
- readWr_i  input  1  load request.
- writeWr_i  input  1  store request.
- rmask_i  input  4  load byte mask: 0001 = byte, 0011 = half, 1111 = word.
- wmask_i  input  4  store byte mask, same encoding as rmask_i.
- ld_sext_i  input  1  1 = sign-extend load result, 0 = zero-extend.
- stall  output  1  1 = upstream must hold its outputs stable.
- dmem_req  output  1  access request.
- dmem_we  output  1  1 = write.
- dmem_addr  output  ADDR_W  word-aligned address (bits [1:0] = 0).
- dmem_wdata  output  32  lane-shifted store data.
- dmem_wstrb  output  4  lane-shifted byte strobe.
- dmem_ready  input  1  access complete; for reads, dmem_rdata is valid in the same cycle.
- dmem_rdata  input  32  read data.
- wb_regcData  output  32  writeback data.
- wb_regcAddr  output  5  writeback address.
- wb_regcWr  output  1  writeback enable.
- misalign  output  1  one-cycle pulse: access rejected as misaligned.
- bus_err  output  1  one-cycle pulse: access aborted by timeout.

Behaviour:
- Reset: all outputs 0; FSM enters IDLE; timeout counter 0.
- Lane offset: off = memAddr_i[1:0].
- Shifted strobe: strb = mask << off.
- Misaligned when any mask bit is shifted out of bit 3. Examples: half at off = 3; word at off != 0.
- IDLE, no memory op (readWr_i = writeWr_i = 0):
  - Capture wb_* <= {regcData_i, regcAddr_i, regcWr_i} on the next edge.
  - Latency is 1 cycle; stall = 0.
- IDLE, memory op, misaligned:
  - No dmem_req is issued.
  - misalign pulses for 1 cycle and wb_regcWr <= 0.
  - Remain in IDLE.
- IDLE, memory op, aligned:
  - Latch address, strobe, wdata = memData_i << (8*off), and ld_sext_i.
  - Go to ACCESS.
  - wb_regcWr <= 0 (a bubble enters WB).
- ACCESS:
  - dmem_req = 1; dmem_we, dmem_addr, dmem_wdata and dmem_wstrb are held stable.
  - stall = 1 combinationally.
  - Counter increments each cycle.
- ACCESS with dmem_ready = 1:
  - Load: shift dmem_rdata right by 8*off; keep the masked bytes; extend per ld_sext_i from bit 7 (byte) or bit 15 (half).
  - Load: wb_regcData <= result, wb_regcWr <= regcWr_i as latched, wb_regcAddr as latched.
  - Store: wb_regcWr <= 0.
  - Return to IDLE; stall drops in the cycle after ready.
- ACCESS with counter == TIMEOUT and no ready:
  - dmem_req drops; bus_err pulses; wb_regcWr <= 0.
  - Return to IDLE; the access is abandoned.
- dmem_ready outside ACCESS is ignored.
- readWr_i and writeWr_i both 1: treated as a store. Any latched load destination is discarded.
- Upstream inputs are sampled only in IDLE; inputs presented while stall = 1 are ignored.
- Reset asserted mid-ACCESS: immediate return to IDLE; dmem_req drops asynchronously; no writeback occurs.

Test Plan:
- ALU passthrough: regcData_i = 0x12345678, regcAddr_i = 5, regcWr_i = 1, no memory op -> next cycle wb_regcData = 0x12345678, wb_regcAddr = 5, wb_regcWr = 1; stall never asserts.
- Signed byte load: memAddr_i = 0x1003, rmask_i = 0001, ld_sext_i = 1, dmem_ready after 3 cycles with rdata 0x80FFFFFF -> dmem_addr = 0x1000, stall high for 3 cycles, then wb_regcData = 0xFFFFFF80.
- Half store: memAddr_i = 0x2002, wmask_i = 0011, memData_i = 0x0000BEEF -> dmem_we = 1, dmem_wstrb = 1100, dmem_wdata = 0xBEEF0000; wb_regcWr = 0.
- Misaligned word: memAddr_i = 0x3001, rmask_i = 1111 -> misalign = 1 for one cycle; no dmem_req; no writeback.
- Timeout: load issued, dmem_ready held at 0 -> bus_err pulses after TIMEOUT cycles, stall drops, FSM returns to IDLE; a following ALU op writes back normally.
- Reset mid-access: rst driven to 0 during ACCESS -> dmem_req = 0 and all outputs 0 immediately; after release, a new load completes correctly.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: passes execute results to writeback and runs
// loads/stores over a ready-handshaked data-memory port with lane alignment.
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       regcData_i,
    input  logic [4:0]        regcAddr_i,
    input  logic              regcWr_i,
    input  logic [31:0]       memAddr_i,
    input  logic [31:0]       memData_i,
    input  logic              readWr_i,
    input  logic              writeWr_i,
    input  logic [3:0]        rmask_i,
    input  logic [3:0]        wmask_i,
    input  logic              ld_sext_i,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata,
    output logic [31:0]       wb_regcData,
    output logic [4:0]        wb_regcAddr,
    output logic              wb_regcWr,
    output logic              misalign,
    output logic              bus_err
);

    // state  | meaning
    // IDLE   | sampling upstream; ALU results pass straight to WB
    // ACCESS | memory request outstanding; upstream stalled
    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              we_q, we_d;
    logic [1:0]        off_q, off_d;
    logic [3:0]        rmask_q, rmask_d;
    logic              sext_q, sext_d;
    logic [4:0]        ld_addr_q, ld_addr_d;
    logic              ld_wr_q, ld_wr_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic              wb_wr_q, wb_wr_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;

    logic [1:0]  off;
    logic [3:0]  mask;
    logic [6:0]  strb_wide;
    logic        is_op;
    logic        is_store;
    logic        misaligned;
    logic [31:0] rdata_sh;
    logic [31:0] rdata_msk;
    logic [31:0] ld_result;

    always_comb begin
        off        = memAddr_i[1:0];
        is_op      = readWr_i | writeWr_i;
        is_store   = writeWr_i;
        mask       = is_store ? wmask_i : rmask_i;
        strb_wide  = {3'b000, mask} << off;
        // Any strobe bit pushed past lane 3 means the access crosses a word.
        misaligned = |strb_wide[6:4];
    end

    always_comb begin
        rdata_sh = dmem_rdata >> {off_q, 3'b000};
        for (int i = 0; i < 4; i++) begin
            rdata_msk[8*i +: 8] = rdata_sh[8*i +: 8] & {8{rmask_q[i]}};
        end
        ld_result = rdata_msk;
        if (sext_q) begin
            if (rmask_q == 4'b0001) begin
                ld_result = {{24{rdata_msk[7]}}, rdata_msk[7:0]};
            end else if (rmask_q == 4'b0011) begin
                ld_result = {{16{rdata_msk[15]}}, rdata_msk[15:0]};
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        we_d       = we_q;
        off_d      = off_q;
        rmask_d    = rmask_q;
        sext_d     = sext_q;
        ld_addr_d  = ld_addr_q;
        ld_wr_d    = ld_wr_q;
        wb_data_d  = wb_data_q;
        wb_addr_d  = wb_addr_q;
        wb_wr_d    = wb_wr_q;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!is_op) begin
                    wb_data_d = regcData_i;
                    wb_addr_d = regcAddr_i;
                    wb_wr_d   = regcWr_i;
                end else if (misaligned) begin
                    misalign_d = 1'b1;
                    wb_wr_d    = 1'b0;
                end else begin
                    addr_d    = {memAddr_i[ADDR_W-1:2], 2'b00};
                    wstrb_d   = strb_wide[3:0];
                    wdata_d   = memData_i << {off, 3'b000};
                    we_d      = is_store;
                    off_d     = off;
                    rmask_d   = rmask_i;
                    sext_d    = ld_sext_i;
                    ld_addr_d = regcAddr_i;
                    // A combined read/write is a store, so no load destination survives.
                    ld_wr_d   = regcWr_i & ~is_store;
                    cnt_d     = 8'd0;
                    wb_wr_d   = 1'b0;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                if (dmem_ready) begin
                    if (we_q) begin
                        wb_wr_d = 1'b0;
                    end else begin
                        wb_data_d = ld_result;
                        wb_addr_d = ld_addr_q;
                        wb_wr_d   = ld_wr_q;
                    end
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else if (cnt_q == TO_CNT) begin
                    bus_err_d = 1'b1;
                    wb_wr_d   = 1'b0;
                    cnt_d     = 8'd0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            we_q       <= 1'b0;
            off_q      <= 2'd0;
            rmask_q    <= 4'd0;
            sext_q     <= 1'b0;
            ld_addr_q  <= 5'd0;
            ld_wr_q    <= 1'b0;
            wb_data_q  <= 32'd0;
            wb_addr_q  <= 5'd0;
            wb_wr_q    <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            we_q       <= we_d;
            off_q      <= off_d;
            rmask_q    <= rmask_d;
            sext_q     <= sext_d;
            ld_addr_q  <= ld_addr_d;
            ld_wr_q    <= ld_wr_d;
            wb_data_q  <= wb_data_d;
            wb_addr_q  <= wb_addr_d;
            wb_wr_q    <= wb_wr_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign stall       = (state_q == ACCESS);
    assign dmem_req    = (state_q == ACCESS);
    assign dmem_we     = (state_q == ACCESS) & we_q;
    assign dmem_wstrb  = (state_q == ACCESS) ? wstrb_q : 4'd0;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign wb_regcData = wb_data_q;
    assign wb_regcAddr = wb_addr_q;
    assign wb_regcWr   = wb_wr_q;
    assign misalign    = misalign_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: passthrough, loads, stores, misalign,
// timeout and asynchronous reset during an access.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] regcData_i = '0;
    logic [4:0]  regcAddr_i = '0;
    logic        regcWr_i = 1'b0;
    logic [31:0] memAddr_i = '0;
    logic [31:0] memData_i = '0;
    logic        readWr_i = 1'b0;
    logic        writeWr_i = 1'b0;
    logic [3:0]  rmask_i = '0;
    logic [3:0]  wmask_i = '0;
    logic        ld_sext_i = 1'b0;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [31:0] wb_regcData;
    logic [4:0]  wb_regcAddr;
    logic        wb_regcWr;
    logic        misalign;
    logic        bus_err;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .regcData_i(regcData_i), .regcAddr_i(regcAddr_i), .regcWr_i(regcWr_i),
        .memAddr_i(memAddr_i), .memData_i(memData_i),
        .readWr_i(readWr_i), .writeWr_i(writeWr_i),
        .rmask_i(rmask_i), .wmask_i(wmask_i), .ld_sext_i(ld_sext_i),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .wb_regcData(wb_regcData), .wb_regcAddr(wb_regcAddr), .wb_regcWr(wb_regcWr),
        .misalign(misalign), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_wb_data", wb_regcData, 0);
        chk("rst_wb_wr", 32'(wb_regcWr), 0);
        chk("rst_addr", dmem_addr, 0);
        @(negedge clk);
        rst = 1'b1;

        // ALU passthrough; stray dmem_ready must be ignored
        regcData_i = 32'h1234_5678; regcAddr_i = 5'd5; regcWr_i = 1'b1;
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("alu_data", wb_regcData, 32'h1234_5678);
        chk("alu_addr", 32'(wb_regcAddr), 5);
        chk("alu_wr", 32'(wb_regcWr), 1);
        chk("alu_stall", 32'(stall), 0);
        chk("alu_req", 32'(dmem_req), 0);

        // misaligned word read
        memAddr_i = 32'h3001; rmask_i = 4'b1111; readWr_i = 1'b1;
        @(negedge clk);
        chk("mis_pulse", 32'(misalign), 1);
        chk("mis_req", 32'(dmem_req), 0);
        chk("mis_wb_wr", 32'(wb_regcWr), 0);
        chk("mis_stall", 32'(stall), 0);
        readWr_i = 1'b0; regcWr_i = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        chk("mis_drop", 32'(misalign), 0);

        // signed byte load, ready in the third access cycle
        memAddr_i = 32'h1003; rmask_i = 4'b0001; ld_sext_i = 1'b1; readWr_i = 1'b1;
        regcAddr_i = 5'd7; regcWr_i = 1'b1;
        @(posedge clk); #1;
        chk("lb_stall", 32'(stall), 1);
        chk("lb_req", 32'(dmem_req), 1);
        chk("lb_addr", dmem_addr, 32'h1000);
        chk("lb_we", 32'(dmem_we), 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            readWr_i = 1'b0;
            if (!stall) break;
            n++;
            if (n == 3) begin
                dmem_ready = 1'b1; dmem_rdata = 32'h80FF_FFFF;
            end
        end
        chk("lb_stall_cycles", 32'(n), 3);
        chk("lb_data", wb_regcData, 32'hFFFF_FF80);
        chk("lb_addr_wb", 32'(wb_regcAddr), 7);
        chk("lb_wr", 32'(wb_regcWr), 1);
        dmem_ready = 1'b0;

        // half store at lane 2
        memAddr_i = 32'h2002; wmask_i = 4'b0011; memData_i = 32'h0000_BEEF; writeWr_i = 1'b1;
        regcWr_i = 1'b1;
        @(posedge clk); #1;
        chk("sh_we", 32'(dmem_we), 1);
        chk("sh_strb", 32'(dmem_wstrb), 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hBEEF_0000);
        chk("sh_addr", dmem_addr, 32'h2000);
        chk("sh_bubble", 32'(wb_regcWr), 0);
        @(negedge clk);
        writeWr_i = 1'b0; regcWr_i = 1'b0; dmem_ready = 1'b1;
        @(negedge clk);
        chk("sh_done_stall", 32'(stall), 0);
        chk("sh_done_wr", 32'(wb_regcWr), 0);
        chk("sh_done_req", 32'(dmem_req), 0);
        dmem_ready = 1'b0;

        // read and write together behave as a store
        memAddr_i = 32'h6000; wmask_i = 4'b1111; rmask_i = 4'b0001; memData_i = 32'hCAFE_F00D;
        readWr_i = 1'b1; writeWr_i = 1'b1; regcWr_i = 1'b1;
        @(posedge clk); #1;
        chk("rw_we", 32'(dmem_we), 1);
        chk("rw_strb", 32'(dmem_wstrb), 32'hF);
        chk("rw_wdata", dmem_wdata, 32'hCAFE_F00D);
        @(negedge clk);
        readWr_i = 1'b0; writeWr_i = 1'b0; regcWr_i = 1'b0;
        dmem_ready = 1'b1; dmem_rdata = 32'h1111_1111;
        @(negedge clk);
        chk("rw_wb_wr", 32'(wb_regcWr), 0);
        dmem_ready = 1'b0;

        // timeout with dmem_ready held low
        memAddr_i = 32'h4000; rmask_i = 4'b1111; readWr_i = 1'b1; regcWr_i = 1'b1; regcAddr_i = 5'd4;
        @(posedge clk);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            readWr_i = 1'b0;
            if (bus_err) break;
            if (stall) n++;
        end
        chk("to_cycles", 32'(n), 256);
        chk("to_bus_err", 32'(bus_err), 1);
        chk("to_stall", 32'(stall), 0);
        chk("to_req", 32'(dmem_req), 0);
        chk("to_wb_wr", 32'(wb_regcWr), 0);
        regcData_i = 32'hA5A5_A5A5; regcAddr_i = 5'd9; regcWr_i = 1'b1;
        @(negedge clk);
        chk("to_err_drop", 32'(bus_err), 0);
        chk("to_alu_data", wb_regcData, 32'hA5A5_A5A5);
        chk("to_alu_wr", 32'(wb_regcWr), 1);

        // reset during an access, then the pending load completes
        memAddr_i = 32'h5002; rmask_i = 4'b0011; ld_sext_i = 1'b0; readWr_i = 1'b1;
        regcAddr_i = 5'd3; regcWr_i = 1'b1;
        @(posedge clk); #1;
        chk("mr_req_before", 32'(dmem_req), 1);
        #2 rst = 1'b0;
        #1;
        chk("mr_req", 32'(dmem_req), 0);
        chk("mr_stall", 32'(stall), 0);
        chk("mr_addr", dmem_addr, 0);
        chk("mr_wb_data", wb_regcData, 0);
        chk("mr_wb_wr", 32'(wb_regcWr), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mr2_req", 32'(dmem_req), 1);
        chk("mr2_addr", dmem_addr, 32'h5000);
        @(negedge clk);
        readWr_i = 1'b0; regcWr_i = 1'b0;
        dmem_ready = 1'b1; dmem_rdata = 32'hABCD_8001;
        @(negedge clk);
        dmem_ready = 1'b0;
        chk("mr2_data", wb_regcData, 32'h0000_ABCD);
        chk("mr2_addr_wb", 32'(wb_regcAddr), 3);
        chk("mr2_wr", 32'(wb_regcWr), 1);
        chk("mr2_stall", 32'(stall), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
